libhdl_sync_count_mc: RTL and testbench

Multi-channel receive-side synchroniser for Gray-coded counters. Each source domain registers its counter in Gray code and drives it asynchronously into this block. The block synchronises every channel into one destination clock, decodes it to binary, and reports the per-sample increment. It also flags samples whose Gray code jumped by more than one bit, which means the source stepped faster than the destination can track. It is the destination half used by FIFO pointer and event-counter crossings.

---
 rtl/libhdl_sync_count_pkg.sv | 30 +++
 rtl/libhdl_sync_count_ch.sv | 70 +++++++
 rtl/libhdl_sync_count_mc.sv | 55 +++++
 tb/tb_libhdl_sync_count_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/libhdl_sync_count_pkg.sv
// rtl/libhdl_sync_count_pkg.sv - Gray/binary helpers and shared constants for the count synchroniser
package libhdl_sync_count_pkg;

   // Helpers work on zero-extended values, so any width up to MAXW is handled by casting.
   localparam int MAXW  = 64;
   localparam int ARM_W = 8;

   function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
      logic [MAXW-1:0] b;
      b[MAXW-1] = g[MAXW-1];
      for (int i = MAXW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int popcount(input logic [MAXW-1:0] x);
      int n;
      n = 0;
      for (int i = 0; i < MAXW; i++) begin
         n = n + int'(x[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/libhdl_sync_count_ch.sv
// rtl/libhdl_sync_count_ch.sv - one channel: sync chain, Gray decode, delta and sticky overrun flag
module libhdl_sync_count_ch
   import libhdl_sync_count_pkg::*;
#(
   parameter int            W        = 8,
   parameter int            NFF      = 2,
   parameter logic [W-1:0]  INIT_VAL = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_arm,
   input  logic [W-1:0]  i_gray,
   input  logic          i_err_clr,
   output logic [W-1:0]  o_count,
   output logic [W-1:0]  o_delta,
   output logic          o_upd,
   output logic          o_err
);

   localparam logic [W-1:0] INIT_G = W'(bin2gray(MAXW'(INIT_VAL)));

   (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q [NFF];

   logic [W-1:0] gq_q;
   logic [W-1:0] count_q;
   logic [W-1:0] delta_q;
   logic         upd_q;
   logic         err_q;
   logic         err_d;
   logic [W-1:0] g;
   logic [W-1:0] bin_g;
   logic [W-1:0] bin_gq;
   logic         jump;

   always_comb begin
      g      = sync_q[NFF-1];
      bin_g  = W'(gray2bin(MAXW'(g)));
      bin_gq = W'(gray2bin(MAXW'(gq_q)));
      jump   = popcount(MAXW'(g ^ gq_q)) > 1;
      // A fresh overrun outranks a clear arriving on the same edge.
      err_d  = err_q;
      if (i_err_clr) err_d = 1'b0;
      if (i_arm && jump) err_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NFF; i++) sync_q[i] <= INIT_G;
         gq_q    <= INIT_G;
         count_q <= INIT_VAL;
         delta_q <= '0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q[0] <= i_gray;
         for (int i = 1; i < NFF; i++) sync_q[i] <= sync_q[i-1];
         gq_q    <= g;
         count_q <= bin_g;
         delta_q <= bin_g - bin_gq;
         upd_q   <= (g != gq_q);
         err_q   <= err_d;
      end
   end

   assign o_count = count_q;
   assign o_delta = delta_q;
   assign o_upd   = upd_q;
   assign o_err   = err_q;

endmodule

// File: rtl/libhdl_sync_count_mc.sv
// rtl/libhdl_sync_count_mc.sv - multi-channel Gray counter synchroniser with shared arming counter
module libhdl_sync_count_mc
   import libhdl_sync_count_pkg::*;
#(
   parameter int            W        = 8,
   parameter int            NCH      = 1,
   parameter int            NFF      = 2,
   parameter logic [W-1:0]  INIT_VAL = {W{1'b0}}
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NCH*W-1:0]  i_gray,
   input  logic [NCH-1:0]    i_err_clr,
   output logic [NCH*W-1:0]  o_count,
   output logic [NCH*W-1:0]  o_delta,
   output logic [NCH-1:0]    o_upd,
   output logic [NCH-1:0]    o_err
);

   // The first compare after release sees INIT_VAL against the live input; keep it disarmed.
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(NFF + 1);

   logic [ARM_W-1:0] arm_cnt_q;
   logic [ARM_W-1:0] arm_cnt_d;
   logic             armed;

   always_comb begin
      armed     = (arm_cnt_q == ARM_DONE);
      arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) arm_cnt_q <= '0;
      else       arm_cnt_q <= arm_cnt_d;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      libhdl_sync_count_ch #(
         .W        (W),
         .NFF      (NFF),
         .INIT_VAL (INIT_VAL)
      ) u_ch (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_arm     (armed),
         .i_gray    (i_gray[c*W +: W]),
         .i_err_clr (i_err_clr[c]),
         .o_count   (o_count[c*W +: W]),
         .o_delta   (o_delta[c*W +: W]),
         .o_upd     (o_upd[c]),
         .o_err     (o_err[c])
      );
   end

endmodule

// File: tb/tb_libhdl_sync_count_mc.sv
// tb/tb_libhdl_sync_count_mc.sv - scoreboard bench for the multi-channel Gray count synchroniser
module tb_libhdl_sync_count_mc;

   localparam logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   typedef struct packed {
      logic [3:0] count;
      logic [3:0] delta;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] gray;
   logic [1:0] clr;
   logic [7:0] count;
   logic [7:0] delta;
   logic [1:0] upd;
   logic [1:0] err;

   logic       rst3;
   logic [3:0] gray3;
   logic       clr3;
   logic [3:0] count3;
   logic [3:0] delta3;
   logic       upd3;
   logic       err3;

   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   libhdl_sync_count_mc #(.W(4), .NCH(2), .NFF(2), .INIT_VAL(4'd0)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_gray    (gray),
      .i_err_clr (clr),
      .o_count   (count),
      .o_delta   (delta),
      .o_upd     (upd),
      .o_err     (err)
   );

   libhdl_sync_count_mc #(.W(4), .NCH(1), .NFF(3), .INIT_VAL(4'd0)) dut3 (
      .i_clk     (clk),
      .i_rst     (rst3),
      .i_gray    (gray3),
      .i_err_clr (clr3),
      .o_count   (count3),
      .o_delta   (delta3),
      .o_upd     (upd3),
      .o_err     (err3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input int c, input int d, input logic e);
      q0.push_back('{count: 4'(c), delta: 4'(d), err: e});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (upd[0] === 1'b1) begin
         if (q0.size() == 0) begin
            chk("ch0_unexpected_upd", 32'(count[3:0]), 32'hFFFF);
         end else begin
            e = q0.pop_front();
            chk("ch0_count", 32'(count[3:0]), 32'(e.count));
            chk("ch0_delta", 32'(delta[3:0]), 32'(e.delta));
            chk("ch0_err",   32'(err[0]),     32'(e.err));
         end
      end
      if (upd[1] === 1'b1) begin
         if (q1.size() == 0) begin
            chk("ch1_unexpected_upd", 32'(count[7:4]), 32'hFFFF);
         end else begin
            e = q1.pop_front();
            chk("ch1_count", 32'(count[7:4]), 32'(e.count));
            chk("ch1_delta", 32'(delta[7:4]), 32'(e.delta));
            chk("ch1_err",   32'(err[1]),     32'(e.err));
         end
      end
   end

   initial begin
      rst   = 1'b1;
      gray  = {GRAY[5], GRAY[10]};
      clr   = 2'b00;
      rst3  = 1'b1;
      gray3 = 4'h0;
      clr3  = 1'b0;

      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_count", 32'(count), 32'h00);
         chk("rst_delta", 32'(delta), 32'h00);
         chk("rst_upd",   32'(upd),   32'h0);
         chk("rst_err",   32'(err),   32'h0);
      end
      push0(10, 10, 1'b0);
      q1.push_back('{count: 4'd5, delta: 4'd5, err: 1'b0});
      rst  = 1'b0;
      rst3 = 1'b0;
      repeat (8) step();
      chk("arm_no_err", 32'(err), 32'h0);

      for (int v = 11; v <= 32; v++) begin
         gray[3:0] = GRAY[v % 16];
         push0(v % 16, 1, 1'b0);
         repeat (4) step();
      end
      chk("step_no_err", 32'(err), 32'h0);

      for (int v = 1; v <= 3; v++) begin
         gray[3:0] = GRAY[v];
         push0(v, 1, 1'b0);
         repeat (4) step();
      end
      gray[3:0] = GRAY[6];
      push0(6, 3, 1'b1);
      repeat (4) step();
      chk("ovr_err",   32'(err), 32'h1);
      chk("ovr_count", 32'(count[3:0]), 32'h6);
      repeat (5) step();
      chk("ovr_sticky", 32'(err), 32'h1);

      gray[3:0] = GRAY[0];
      push0(0, 10, 1'b1);
      step();
      step();
      clr = 2'b01;
      step();
      clr = 2'b00;
      chk("collision_set_wins", 32'(err), 32'h1);
      step();
      chk("collision_hold", 32'(err), 32'h1);
      clr = 2'b01;
      step();
      clr = 2'b00;
      chk("clear_alone", 32'(err), 32'h0);
      repeat (2) step();

      gray[3:0] = GRAY[9];
      push0(9, 9, 1'b1);
      repeat (4) step();
      chk("pre_rst_count", 32'(count[3:0]), 32'h9);
      chk("pre_rst_err",   32'(err), 32'h1);
      push0(9, 9, 1'b0);
      q1.push_back('{count: 4'd5, delta: 4'd5, err: 1'b0});
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_count", 32'(count), 32'h00);
      chk("midrst_err",   32'(err), 32'h0);
      chk("midrst_upd",   32'(upd), 32'h0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rearm_no_err", 32'(err), 32'h0);
      end

      gray3 = GRAY[1];
      step();
      chk("lat3_k",   32'(count3), 32'h0);
      step();
      chk("lat3_k1",  32'(count3), 32'h0);
      step();
      chk("lat3_k2",  32'(count3), 32'h0);
      chk("lat3_k2_upd", 32'(upd3), 32'h0);
      step();
      chk("lat3_k3",  32'(count3), 32'h1);
      chk("lat3_upd", 32'(upd3), 32'h1);
      chk("lat3_delta", 32'(delta3), 32'h1);
      step();
      chk("lat3_upd_pulse", 32'(upd3), 32'h0);
      chk("lat3_err", 32'(err3), 32'h0);

      repeat (4) step();
      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
